fir_transposed_param: RTL and testbench
=======================================

Name: fir_transposed_param

Overview:
- Next-generation transposed-form FIR filter, generalised in data width, coefficient width, tap count and output scaling.
- Adds a sample-valid strobe, a run-time coefficient write port with a shadow/active double bank, rounding and saturation on the output, flush and bypass.
- Sits between the noisy-signal source and the filtered-signal consumer in the filter datapath.

Parameters:
- DW, 16, input sample width (signed).
- CW, 16, coefficient width (signed).
- TAPS, 51, number of taps; legal range ≥2.
- OW, 16, output width (signed).
- OUT_SHIFT, 16, arithmetic right shift applied to the accumulator before output; 0 allowed.
- AW, $clog2(TAPS), coefficient address width (derived).
- ACC_W, DW+CW+$clog2(TAPS), internal accumulator width (derived).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  reset; active low, asynchronous assert.
- in_valid  in  1  in_data valid this cycle.
- in_data  in  DW  signed input sample.
- coef_we  in  1  write coef_wdata to shadow[coef_addr].
- coef_addr  in  AW  shadow coefficient index; c[0] multiplies the newest sample.
- coef_wdata  in  CW  signed coefficient.
- coef_commit  in  1  copy the shadow bank into the active bank.
- flush  in  1  synchronous clear of the delay chain.
- bypass  in  1  output the input sample directly instead of the filter result.
- out_valid  out  1  out_data valid.
- out_data  out  OW  signed filtered sample.
- out_sat  out  1  out_data was saturated (qualified by out_valid).

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - delay-chain registers, shadow bank and active bank to 0;
  - out_valid, out_data and out_sat to 0.
- Release of reset is synchronous to clk.
- Filter function: y[n] = sum over k=0..TAPS-1 of c[k]·x[n−k], computed at full ACC_W precision with sign extension and no intermediate truncation.
- Transposed structure:
  - every tap multiplies the current in_data;
  - the partial-sum registers advance only on cycles with in_valid=1;
  - with in_valid=0 the chain holds its value, so gaps between samples are invisible in the result.
- Latency: out_valid pulses exactly 1 cycle after each in_valid, with no other out_valid cycles. out_data and out_sat hold their values between valid pulses.
- Output scaling:
  - when OUT_SHIFT>0: r = (acc + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT, i.e. round half toward +inf;
  - when OUT_SHIFT=0: r = acc.
- Saturation:
  - if r > 2^(OW−1)−1, out_data = max and out_sat=1;
  - if r < −2^(OW−1), out_data = min and out_sat=1;
  - otherwise out_data = r[OW−1:0] and out_sat=0.
- Coefficient bank:
  - coef_we writes shadow[coef_addr] at the clock edge;
  - a write with coef_addr ≥ TAPS is ignored;
  - the active bank is unchanged until coef_commit.
- coef_commit:
  - copies all shadow entries to the active bank at the edge;
  - a coef_we in the same cycle is included in the copy;
  - a sample arriving in the same cycle as the commit uses the old active bank; the next sample uses the new one.
- The delay chain is not cleared by a commit, so the transition mixes old partial sums with new coefficients. Software must flush if a clean start is needed.
- flush:
  - clears all partial-sum registers at the edge; coefficient banks are untouched;
  - flush with in_valid in the same cycle: flush wins for the chain, but out_valid still pulses and out_data reflects c[0]·in_data only;
  - the output registers themselves are not cleared by flush.
- bypass=1:
  - out_data = saturate(in_data sign-extended to ACC_W) to OW, with no shift and the same latency and out_valid timing;
  - the chain keeps updating, so deasserting bypass yields a correct y[n] immediately.
  - bypass is sampled in the in_valid cycle.
- Reset mid-stream: all state is cleared immediately and the first post-reset output reflects an all-zero history and zero coefficients (out_data=0).

Test Plan:
1. Impulse response (TAPS=4, OW=16, OUT_SHIFT=0):
   - write c={1,2,3,4}, commit, then feed 1,0,0,0,0 on consecutive cycles;
   - required: out_data = 1,2,3,4,0, each 1 cycle after its in_valid, out_sat=0.
2. Gapped input:
   - same setup, impulse then zeros with in_valid only every 3rd cycle;
   - required: out_data sequence identical to test 1, out_valid only 1 cycle after each in_valid.
3. Saturation (OUT_SHIFT=0):
   - c={32767,32767,32767,32767}, steady in_data=32767 → out_data=32767, out_sat=1;
   - steady −32768 → out_data=−32768, out_sat=1.
4. Rounding (OUT_SHIFT=1, c={1,0,0,0}):
   - in_data=3 → out_data=2;
   - in_data=−3 → out_data=−1;
   - in_data=4 → out_data=2.
5. Commit collision:
   - shadow c0 changed 1→5 with coef_commit asserted in the same cycle as in_valid (x=1);
   - required: that output is 1 (old bank); the next sample x=1 yields 5 plus the old-coefficient history terms.
   - write to coef_addr=TAPS has no effect.
6. Flush / bypass / reset:
   - flush after ramp input → next impulse output equals test 1;
   - bypass=1 with in_data=−7 → out_data=−7;
   - reset asserted mid-stream → all outputs 0 asynchronously, and the post-reset sample gives out_data=0.

Source files
------------

// File: rtl/fir_transposed_param.sv
// Transposed-form FIR with a sample-valid strobe, a shadow/active coefficient bank,
// round-half-up output scaling, saturation, flush and bypass.
module fir_transposed_param #(
    parameter int DW        = 16,
    parameter int CW        = 16,
    parameter int TAPS      = 51,
    parameter int OW        = 16,
    parameter int OUT_SHIFT = 16,
    parameter int AW        = $clog2(TAPS),
    parameter int ACC_W     = DW + CW + $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    input  logic                 coef_commit,
    input  logic                 flush,
    input  logic                 bypass,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sat
);

    localparam int PW = DW + CW;
    // Two guard bits above the wider of ACC_W/OW keep rounding and clamping overflow-free.
    localparam int RW = ((OW > ACC_W) ? OW : ACC_W) + 2;

    localparam logic signed [RW-1:0] MAX_R = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_R = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [PW-1:0]    x_ext;
    logic signed [ACC_W-1:0] prod    [TAPS];
    logic signed [ACC_W-1:0] chain_q [TAPS-1];

    assign x_ext = {{CW{in_data[DW-1]}}, in_data};

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            logic signed [CW-1:0] shadow_reg;
            logic signed [CW-1:0] active_reg;
            logic signed [CW-1:0] shadow_next;
            logic signed [PW-1:0] c_ext;
            logic signed [PW-1:0] mult;
            logic                 hit;

            // Out-of-range addresses match no tap, so those writes fall away naturally.
            assign hit         = coef_we && (32'(coef_addr) == gi);
            assign shadow_next = hit ? coef_wdata : shadow_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    shadow_reg <= shadow_next;
                    if (coef_commit) begin
                        active_reg <= shadow_next;
                    end
                end
            end

            assign c_ext    = {{DW{active_reg[CW-1]}}, active_reg};
            assign mult     = c_ext * x_ext;
            assign prod[gi] = {{(ACC_W-PW){mult[PW-1]}}, mult};
        end

        // chain_q[k] holds the partial sum that feeds tap k's output adder.
        for (gi = 0; gi < TAPS - 1; gi++) begin : g_chain
            logic signed [ACC_W-1:0] chain_reg;
            logic signed [ACC_W-1:0] chain_next;

            if (gi == TAPS - 2) begin : g_last
                assign chain_next = prod[gi+1];
            end else begin : g_mid
                assign chain_next = prod[gi+1] + chain_q[gi+1];
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    chain_reg <= '0;
                end else if (flush) begin
                    chain_reg <= '0;
                end else if (in_valid) begin
                    chain_reg <= chain_next;
                end
            end

            assign chain_q[gi] = chain_reg;
        end
    endgenerate

    logic signed [ACC_W-1:0] hist;
    logic signed [ACC_W-1:0] acc;
    logic signed [RW-1:0]    acc_ext;
    logic signed [RW-1:0]    scaled;
    logic signed [RW-1:0]    byp_ext;
    logic signed [RW-1:0]    sel;

    // A flush in the sample cycle discards history for this output as well.
    assign hist    = flush ? '0 : chain_q[0];
    assign acc     = prod[0] + hist;
    assign acc_ext = {{(RW-ACC_W){acc[ACC_W-1]}}, acc};
    assign byp_ext = {{(RW-DW){in_data[DW-1]}}, in_data};

    generate
        if (OUT_SHIFT > 0) begin : g_round
            localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
            logic signed [RW-1:0] rounded;
            assign rounded = acc_ext + HALF;
            assign scaled  = rounded >>> OUT_SHIFT;
        end else begin : g_noround
            assign scaled = acc_ext;
        end
    endgenerate

    assign sel = bypass ? byp_ext : scaled;

    logic signed [OW-1:0] sat_data;
    logic                 sat_flag;

    always_comb begin
        sat_data = sel[OW-1:0];
        sat_flag = 1'b0;
        if (sel > MAX_R) begin
            sat_data = MAX_R[OW-1:0];
            sat_flag = 1'b1;
        end else if (sel < MIN_R) begin
            sat_data = MIN_R[OW-1:0];
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= sat_data;
                out_sat  <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_fir_transposed_param.sv
// Directed bench: a 4-tap unscaled instance and a 5-tap instance with OUT_SHIFT=1 share stimulus.
module tb_fir_transposed_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, in_valid, coef_we, coef_commit, flush, bypass;
    logic signed [15:0] in_data, coef_wdata;
    logic [2:0]         coef_addr;
    logic               we0;

    logic               out_valid0, out_sat0, out_valid1, out_sat1;
    logic signed [15:0] out_data0, out_data1;

    int checks = 0;
    int errors = 0;

    // The 4-tap instance has a 2-bit address; keep it out of writes aimed beyond its range.
    assign we0 = coef_we && (coef_addr < 3'd4);

    fir_transposed_param #(.DW(16), .CW(16), .TAPS(4), .OW(16), .OUT_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .coef_we(we0), .coef_addr(coef_addr[1:0]), .coef_wdata(coef_wdata),
        .coef_commit(coef_commit), .flush(flush), .bypass(bypass),
        .out_valid(out_valid0), .out_data(out_data0), .out_sat(out_sat0)
    );

    fir_transposed_param #(.DW(16), .CW(16), .TAPS(5), .OW(16), .OUT_SHIFT(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_commit(coef_commit), .flush(flush), .bypass(bypass),
        .out_valid(out_valid1), .out_data(out_data1), .out_sat(out_sat1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input int d, input int s);
        chk({tag, ".valid"}, out_valid0, 1);
        chk({tag, ".data"}, out_data0, d);
        chk({tag, ".sat"}, out_sat0, s);
    endtask

    task automatic chk1(input string tag, input int d);
        chk({tag, ".valid1"}, out_valid1, 1);
        chk({tag, ".data1"}, out_data1, d);
    endtask

    task automatic send(input int x, input bit byp, input bit fl);
        in_valid = 1'b1;
        in_data  = 16'(x);
        bypass   = byp;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        bypass   = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wr(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = 3'(a);
        coef_wdata = 16'(v);
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic load_1234();
        for (int i = 0; i < 4; i++) wr(i, i + 1);
        commit();
    endtask

    initial begin
        int imp_exp[5];
        int sat_d[4];
        imp_exp = '{1, 2, 3, 4, 0};
        sat_d   = '{-32768, -32768, -32768, 32767};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0;
        coef_wdata = '0; coef_commit = 1'b0; flush = 1'b0; bypass = 1'b0;
        tick();
        tick();
        chk("rst.valid", out_valid0, 0);
        chk("rst.data", out_data0, 0);
        chk("rst.sat", out_sat0, 0);
        chk("rst.valid1", out_valid1, 0);
        reset = 1'b1;
        tick();

        // Impulse response.
        load_1234();
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 1 : 0, 1'b0, 1'b0);
            chk0($sformatf("imp%0d", i), imp_exp[i], 0);
        end
        tick();
        chk("imp.idle", out_valid0, 0);

        // Gapped input: two idle cycles between samples.
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 1 : 0, 1'b0, 1'b0);
            chk0($sformatf("gap%0d", i), imp_exp[i], 0);
            tick();
            chk($sformatf("gap%0d.idle_valid", i), out_valid0, 0);
            chk($sformatf("gap%0d.hold", i), out_data0, imp_exp[i]);
            tick();
            chk($sformatf("gap%0d.idle2", i), out_valid0, 0);
        end

        // Saturation, both directions.
        for (int i = 0; i < 4; i++) wr(i, 32767);
        commit();
        for (int i = 0; i < 4; i++) begin
            send(32767, 1'b0, 1'b0);
            chk0($sformatf("satp%0d", i), 32767, 1);
        end
        for (int i = 0; i < 4; i++) begin
            send(-32768, 1'b0, 1'b0);
            chk0($sformatf("satn%0d", i), sat_d[3 - i], 1);
        end

        // Rounding on the OUT_SHIFT=1 instance; unscaled instance passes acc through.
        pulse_reset();
        wr(0, 1);
        commit();
        send(3, 1'b0, 1'b0);  chk1("rnd3", 2);   chk0("raw3", 3, 0);
        send(-3, 1'b0, 1'b0); chk1("rndm3", -1); chk0("rawm3", -3, 0);
        send(4, 1'b0, 1'b0);  chk1("rnd4", 2);   chk0("raw4", 4, 0);
        send(-4, 1'b0, 1'b0); chk1("rndm4", -2);
        send(-1, 1'b0, 1'b0); chk1("rndm1", 0);
        send(1, 1'b0, 1'b0);  chk1("rnd1", 1);

        // Commit in the same cycle as a sample and a coefficient write.
        load_1234();
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'sd5; coef_commit = 1'b1;
        send(1, 1'b0, 1'b0);
        coef_we = 1'b0; coef_commit = 1'b0;
        chk0("cc.old", 1, 0);
        send(1, 1'b0, 1'b0); chk0("cc.new", 7, 0);
        send(0, 1'b0, 1'b0); chk0("cc.t2", 5, 0);
        send(0, 1'b0, 1'b0); chk0("cc.t3", 7, 0);
        send(0, 1'b0, 1'b0); chk0("cc.t4", 4, 0);
        send(0, 1'b0, 1'b0); chk0("cc.t5", 0, 0);

        // Out-of-range write ignored; last tap of the 5-tap instance.
        pulse_reset();
        wr(7, 100);
        wr(4, 2);
        commit();
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 1 : 0, 1'b0, 1'b0);
            chk1($sformatf("oor%0d", i), (i == 4) ? 1 : 0);
        end

        // Flush after a ramp, then flush colliding with a sample.
        pulse_reset();
        load_1234();
        send(1, 1'b0, 1'b0); chk0("ramp1", 1, 0);
        send(2, 1'b0, 1'b0); chk0("ramp2", 4, 0);
        send(3, 1'b0, 1'b0); chk0("ramp3", 10, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl.valid", out_valid0, 0);
        chk("fl.hold", out_data0, 10);
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 1 : 0, 1'b0, 1'b0);
            chk0($sformatf("flimp%0d", i), imp_exp[i], 0);
        end
        send(5, 1'b0, 1'b0); chk0("pre5a", 5, 0);
        send(5, 1'b0, 1'b0); chk0("pre5b", 15, 0);
        send(1, 1'b0, 1'b1); chk0("flv", 1, 0);
        send(0, 1'b0, 1'b0); chk0("flv.next", 0, 0);

        // Bypass, then the chain is still correct once bypass drops.
        send(-7, 1'b1, 1'b0); chk0("byp", -7, 0); chk1("byp", -7);
        send(0, 1'b0, 1'b0);  chk0("byp.after", -14, 0);
        send(5, 1'b0, 1'b0);  chk0("byp.after2", -16, 0);

        // Asynchronous reset mid-cycle.
        #2 reset = 1'b0;
        #1;
        chk("arst.valid", out_valid0, 0);
        chk("arst.data", out_data0, 0);
        chk("arst.sat", out_sat0, 0);
        chk("arst.data1", out_data1, 0);
        tick();
        reset = 1'b1;
        tick();
        send(3, 1'b0, 1'b0); chk0("post_rst", 0, 0); chk1("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
